// File: rtl/video_source_gol_zoom.sv
// video_source_gol_zoom: zoomed/panned Game-of-Life viewer mapping pixels to cells and colours via a palette
module video_source_gol_zoom #(
  parameter int RAM_LAT   = 1,
  parameter int SPECIES_W = 5,
  parameter int H_ACTIVE  = 1280,
  parameter int V_ACTIVE  = 720
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [11:0]          pixel_x_i,
  input  logic [11:0]          pixel_y_i,
  input  logic                 de_i,
  input  logic                 frame_start_i,
  input  logic [1:0]           cfg_zoom_i,
  input  logic [7:0]           cfg_pan_x_i,
  input  logic [7:0]           cfg_pan_y_i,
  input  logic                 cfg_grid_en_i,
  input  logic                 cfg_cursor_en_i,
  input  logic [7:0]           cfg_cursor_x_i,
  input  logic [7:0]           cfg_cursor_y_i,
  input  logic                 pal_we_i,
  input  logic [SPECIES_W-1:0] pal_addr_i,
  input  logic [23:0]          pal_data_i,
  output logic [15:0]          addr_o,
  input  logic [SPECIES_W-1:0] dout_i,
  output logic [7:0]           r_o,
  output logic [7:0]           g_o,
  output logic [7:0]           b_o,
  output logic                 de_out_o
);
  localparam logic [23:0] BG_RGB   = 24'h080818;
  localparam logic [23:0] GRID_RGB = 24'h202040;

  logic [1:0]  zoom_q, zoom_d;
  logic [7:0]  pan_x_q, pan_x_d, pan_y_q, pan_y_d, cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic        grid_en_q, grid_en_d, cursor_en_q, cursor_en_d;
  logic [12:0] span, win_w, win_h, ox, oy, px, py, dx, dy;
  logic [7:0]  cell_x, cell_y;
  logic [2:0]  mask;
  logic        in_grid, grid, cursor;
  logic [15:0] addr_q, addr_d;
  logic [3:0]  flags_d, fl;
  logic [RAM_LAT:0][3:0] pipe_q;
  logic [23:0] pal_q [2**SPECIES_W];
  logic [23:0] pal, rgb_q, rgb_d;
  logic        de_out_q;

  // Config is only swapped at frame_start so a frame never mixes settings
  always_comb begin
    zoom_d      = frame_start_i ? cfg_zoom_i      : zoom_q;
    pan_x_d     = frame_start_i ? cfg_pan_x_i     : pan_x_q;
    pan_y_d     = frame_start_i ? cfg_pan_y_i     : pan_y_q;
    grid_en_d   = frame_start_i ? cfg_grid_en_i   : grid_en_q;
    cursor_en_d = frame_start_i ? cfg_cursor_en_i : cursor_en_q;
    cur_x_d     = frame_start_i ? cfg_cursor_x_i  : cur_x_q;
    cur_y_d     = frame_start_i ? cfg_cursor_y_i  : cur_y_q;
  end

  // Active config registers
  always_ff @(posedge clk) begin
    if (rst) begin
      zoom_q <= 2'd2; pan_x_q <= '0; pan_y_q <= '0; grid_en_q <= 1'b0;
      cursor_en_q <= 1'b0; cur_x_q <= '0; cur_y_q <= '0;
    end else begin
      zoom_q <= zoom_d; pan_x_q <= pan_x_d; pan_y_q <= pan_y_d; grid_en_q <= grid_en_d;
      cursor_en_q <= cursor_en_d; cur_x_q <= cur_x_d; cur_y_q <= cur_y_d;
    end
  end

  // Pixel -> centred window, cell coordinate and sideband flags
  always_comb begin
    span    = 13'd256 << zoom_q;
    win_w   = span > 13'(H_ACTIVE) ? 13'(H_ACTIVE) : span;
    win_h   = span > 13'(V_ACTIVE) ? 13'(V_ACTIVE) : span;
    ox      = (13'(H_ACTIVE) - win_w) >> 1;
    oy      = (13'(V_ACTIVE) - win_h) >> 1;
    px      = {1'b0, pixel_x_i};
    py      = {1'b0, pixel_y_i};
    dx      = px - ox;
    dy      = py - oy;
    in_grid = px >= ox && px < ox + win_w && py >= oy && py < oy + win_h;
    cell_x  = 8'(dx >> zoom_q) + pan_x_q;
    cell_y  = 8'(dy >> zoom_q) + pan_y_q;
    mask    = 3'((4'd1 << zoom_q) - 4'd1);
    grid    = grid_en_q && zoom_q >= 2'd2 && ((dx[2:0] & mask) == 3'd0 || (dy[2:0] & mask) == 3'd0);
    cursor  = cursor_en_q && cell_x == cur_x_q && cell_y == cur_y_q;
    addr_d  = in_grid ? {cell_y, cell_x} : 16'h0000;
    flags_d = {de_i, in_grid, grid, cursor};
  end

  // Address register plus flag delay line matching the bank read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      pipe_q <= '0;
    end else begin
      addr_q <= addr_d;
      pipe_q <= {pipe_q[RAM_LAT-1:0], flags_d};
    end
  end

  // Palette; a write lands at the edge so a same-cycle read sees the old entry
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**SPECIES_W; i++) pal_q[i] <= (i == 0) ? 24'h0C0C18 : 24'hFFFFFF;
    end else if (pal_we_i) begin
      pal_q[pal_addr_i] <= pal_data_i;
    end
  end

  // Colour select, flags aligned with dout: {de, in_grid, grid, cursor}
  always_comb begin
    fl    = pipe_q[RAM_LAT];
    pal   = pal_q[dout_i];
    rgb_d = (!fl[3] || !fl[2]) ? BG_RGB : fl[1] ? GRID_RGB : fl[0] ? ~pal : pal;
  end

  // Output register
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q    <= BG_RGB;
      de_out_q <= 1'b0;
    end else begin
      rgb_q    <= rgb_d;
      de_out_q <= fl[3];
    end
  end

  assign addr_o   = addr_q;
  assign {r_o, g_o, b_o} = rgb_q;
  assign de_out_o = de_out_q;
endmodule

// File: tb/tb_video_source_gol_zoom.sv
// tb_video_source_gol_zoom: directed checks of addressing, config latching, latency and colour priority
module tb_video_source_gol_zoom;
  logic        clk = 1'b0, rst = 1'b1;
  logic [11:0] pixel_x = '0, pixel_y = '0;
  logic        de = 1'b0, frame_start = 1'b0;
  logic [1:0]  cfg_zoom = 2'd2;
  logic [7:0]  cfg_pan_x = '0, cfg_pan_y = '0, cfg_cursor_x = '0, cfg_cursor_y = '0;
  logic        cfg_grid_en = 1'b0, cfg_cursor_en = 1'b0;
  logic        pal_we = 1'b0;
  logic [4:0]  pal_addr = '0, dout = '0;
  logic [23:0] pal_data = '0;
  logic [15:0] addr;
  logic [7:0]  r, g, b;
  logic        de_out;
  int          total = 0, passed = 0;

  video_source_gol_zoom #(.RAM_LAT(2), .SPECIES_W(5), .H_ACTIVE(1280), .V_ACTIVE(720)) dut (
    .clk(clk), .rst(rst), .pixel_x_i(pixel_x), .pixel_y_i(pixel_y), .de_i(de),
    .frame_start_i(frame_start), .cfg_zoom_i(cfg_zoom), .cfg_pan_x_i(cfg_pan_x),
    .cfg_pan_y_i(cfg_pan_y), .cfg_grid_en_i(cfg_grid_en), .cfg_cursor_en_i(cfg_cursor_en),
    .cfg_cursor_x_i(cfg_cursor_x), .cfg_cursor_y_i(cfg_cursor_y), .pal_we_i(pal_we),
    .pal_addr_i(pal_addr), .pal_data_i(pal_data), .addr_o(addr), .dout_i(dout),
    .r_o(r), .g_o(g), .b_o(b), .de_out_o(de_out)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pix(input int x, input int y, input logic d);
    pixel_x = 12'(x);
    pixel_y = 12'(y);
    de = d;
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [23:0] exp_rgb, input logic exp_de);
    chk({tag, "_rgb"}, {r, g, b}, exp_rgb);
    chk({tag, "_de"}, {23'd0, de_out}, {23'd0, exp_de});
  endtask

  initial begin
    tick(2);
    chk("rst_addr", {8'd0, addr}, 24'h0);
    chk_out("rst", 24'h080818, 1'b0);
    rst = 1'b0;
    // reset config: zoom 2, window 1024x720 at x=128
    pix(128, 0, 1'b1); tick(); chk("a_128_0", {8'd0, addr}, 24'h0000);
    pix(131, 4, 1'b1); tick(); chk("a_131_4", {8'd0, addr}, 24'h0100);
    pix(127, 0, 1'b1); tick(); chk("a_127_0", {8'd0, addr}, 24'h0000);
    pix(0, 0, 1'b0);
    tick(); chk_out("o_128_0", 24'h0C0C18, 1'b1);
    tick(); chk_out("o_131_4", 24'h0C0C18, 1'b1);
    tick(); chk_out("o_127_0", 24'h080818, 1'b1);
    tick(); chk_out("o_idle", 24'h080818, 1'b0);
    // zoom 0: 256x256 window at (512,232)
    cfg_zoom = 2'd0; frame_start = 1'b1; tick(); frame_start = 1'b0;
    pix(512, 232, 1'b1); tick(); chk("z0_first", {8'd0, addr}, 24'h0000);
    pix(767, 487, 1'b1); tick(); chk("z0_last", {8'd0, addr}, 24'hFFFF);
    pix(511, 232, 1'b1); tick(); chk("z0_left", {8'd0, addr}, 24'h0000);
    pix(0, 0, 1'b0);
    tick(2); chk_out("z0_last_o", 24'h0C0C18, 1'b1);
    tick(); chk_out("z0_left_o", 24'h080818, 1'b1);
    // pan wraps; cfg without frame_start ignored
    cfg_zoom = 2'd2; cfg_pan_x = 8'd250; frame_start = 1'b1; tick(); frame_start = 1'b0;
    pix(168, 0, 1'b1); tick(); chk("pan_wrap", {8'd0, addr}, 24'h0004);
    cfg_pan_x = 8'd0; tick(); chk("pan_hold", {8'd0, addr}, 24'h0004);
    // latency: one pixel, visible exactly 4 cycles later
    pix(0, 0, 1'b0); frame_start = 1'b1; tick(); frame_start = 1'b0;
    tick(5);
    dout = 5'd1;
    pix(300, 10, 1'b1); tick(); pix(0, 0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      if (i == 3) chk_out("lat_c3", 24'h080818, 1'b0);
      if (i == 4) chk_out("lat_c4", 24'hFFFFFF, 1'b1);
      if (i == 5) chk_out("lat_c5", 24'h080818, 1'b0);
      if (i < 6) tick();
    end
    // palette write, cursor at (3,5)
    pal_we = 1'b1; pal_addr = 5'd1; pal_data = 24'h112233; tick(); pal_we = 1'b0;
    cfg_cursor_en = 1'b1; cfg_cursor_x = 8'd3; cfg_cursor_y = 8'd5; frame_start = 1'b1; tick(); frame_start = 1'b0;
    pix(140, 20, 1'b1); tick(); chk("cur_addr", {8'd0, addr}, 24'h0503);
    pix(145, 21, 1'b1); tick();
    pix(0, 0, 1'b0);
    tick(2); chk_out("cur_cell", 24'hEEDDCC, 1'b1);
    tick(); chk_out("cur_other", 24'h112233, 1'b1);
    cfg_grid_en = 1'b1; frame_start = 1'b1; tick(); frame_start = 1'b0;
    pix(140, 20, 1'b1); tick();
    pix(143, 23, 1'b1); tick();
    pix(145, 21, 1'b1); tick();
    pix(0, 0, 1'b0);
    tick(); chk_out("grid_line", 24'h202040, 1'b1);
    tick(); chk_out("grid_cur", 24'hEEDDCC, 1'b1);
    tick(); chk_out("grid_off", 24'h112233, 1'b1);
    // reset mid-line clears outputs and restores defaults
    pix(140, 20, 1'b1); tick(3);
    rst = 1'b1; tick(); chk("mid_rst_addr", {8'd0, addr}, 24'h0);
    chk_out("mid_rst", 24'h080818, 1'b0);
    rst = 1'b0;
    tick(3); chk_out("post_rst_c3", 24'h080818, 1'b0);
    tick(); chk_out("post_rst_c4", 24'hFFFFFF, 1'b1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
